// File: rtl/jtag_led_pkg.sv
// Shared types and frame-layout helpers for the JTAG-controlled PWM LED bank.
package jtag_led_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURED = 2'd1,
      SHIFTING = 2'd2,
      COMMIT   = 2'd3
   } state_e;

   // Frame is {wr, addr, data}, data in the low bits, shifted LSB first.
   localparam int DATA_OFS = 0;

   function automatic int frame_len(input int aw, input int dw);
      return 1 + aw + dw;
   endfunction

   function automatic int addr_ofs(input int dw);
      return DATA_OFS + dw;
   endfunction

   function automatic int wr_ofs(input int aw, input int dw);
      return DATA_OFS + dw + aw;
   endfunction

endpackage

// File: rtl/cdc_sync.sv
// Two-flop synchroniser for slow asynchronous level signals entering the clk domain.
module cdc_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pwm_channel.sv
// One LED channel: compares its duty against the shared PWM counter, registered drive.
module pwm_channel #(
   parameter int DATA_WIDTH     = 8,
   parameter bit LED_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] duty,
   input  logic [DATA_WIDTH-1:0] pwm_cnt,
   output logic                  led
);

   logic led_d, led_q;

   always_comb begin
      led_d = (pwm_cnt < duty) ^ LED_ACTIVE_LOW;
   end

   always_ff @(posedge clk) begin
      if (rst) led_q <= LED_ACTIVE_LOW;
      else     led_q <= led_d;
   end

   assign led = led_q;

endmodule

// File: rtl/jtag_pwm_led_bank.sv
// JTAG user-DR register bank: addressed read/write frames with length checking,
// readback via capture, and per-channel PWM LED drive.
module jtag_pwm_led_bank
   import jtag_led_pkg::*;
#(
   parameter int                    CH_COUNT       = 4,
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    ADDR_WIDTH     = 2,
   parameter bit                    LED_ACTIVE_LOW = 1'b1,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tap_tck,
   input  logic                           tap_sel,
   input  logic                           tap_capture,
   input  logic                           tap_shift,
   input  logic                           tap_update,
   input  logic                           tap_tdi,
   output logic                           tap_tdo,
   output logic [CH_COUNT-1:0]            led,
   output logic [CH_COUNT*DATA_WIDTH-1:0] ch_value
);

   localparam int FRAME_LEN = frame_len(ADDR_WIDTH, DATA_WIDTH);
   localparam int ADDR_OFS  = addr_ofs(DATA_WIDTH);
   localparam int WR_OFS    = wr_ofs(ADDR_WIDTH, DATA_WIDTH);
   localparam int CNT_W     = $clog2(FRAME_LEN + 2);
   localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0]      CNT_SAT  = CNT_W'(FRAME_LEN + 1);
   localparam logic [DATA_WIDTH-1:0] PWM_TOP  = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

   logic [5:0] tap_raw, tap_s;
   logic       tck_s, sel_s, cap_s, shift_s, upd_s, tdi_s;
   logic       tck_prev_q, tck_prev_d, upd_prev_q, upd_prev_d;
   logic       tck_rise, upd_rise;

   assign tap_raw = {tap_tck, tap_sel, tap_capture, tap_shift, tap_update, tap_tdi};

   cdc_sync #(.WIDTH(6)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (tap_raw),
      .q   (tap_s)
   );

   assign {tck_s, sel_s, cap_s, shift_s, upd_s, tdi_s} = tap_s;

   // Edges only count while our user chain is selected.
   always_comb begin
      tck_prev_d = tck_s;
      upd_prev_d = upd_s;
      tck_rise   = tck_s & ~tck_prev_q & sel_s;
      upd_rise   = upd_s & ~upd_prev_q & sel_s;
   end

   state_e                               state_q, state_d;
   logic [CH_COUNT-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
   logic [ADDR_WIDTH-1:0]                rd_addr_q, rd_addr_d;
   logic                                 err_q, err_d;
   logic [FRAME_LEN-1:0]                 sr_q, sr_d;
   logic [CNT_W-1:0]                     bit_cnt_q, bit_cnt_d;
   logic                                 tdo_q, tdo_d;
   logic [DATA_WIDTH-1:0]                pwm_cnt_q, pwm_cnt_d;
   logic [DATA_WIDTH-1:0]                rd_data;
   logic [DATA_WIDTH-1:0]                f_data;
   logic [ADDR_WIDTH-1:0]                f_addr;
   logic                                 f_wr;

   assign f_data = sr_q[DATA_OFS +: DATA_WIDTH];
   assign f_addr = sr_q[ADDR_OFS +: ADDR_WIDTH];
   assign f_wr   = sr_q[WR_OFS];

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < CH_COUNT; i++) begin
         if (rd_addr_q == ADDR_WIDTH'(i)) rd_data = regs_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      regs_d    = regs_q;
      rd_addr_d = rd_addr_q;
      err_d     = err_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      tdo_d     = tdo_q;
      if (tck_rise && cap_s) begin
         // Capture presents status + selected register; error is read-to-clear.
         state_d   = CAPTURED;
         sr_d      = {err_q, rd_addr_q, rd_data};
         bit_cnt_d = '0;
         err_d     = 1'b0;
      end else begin
         case (state_q)
            CAPTURED, SHIFTING: begin
               if (upd_rise) begin
                  state_d = COMMIT;
               end else if (tck_rise && shift_s) begin
                  sr_d    = {tdi_s, sr_q[FRAME_LEN-1:1]};
                  tdo_d   = sr_q[0];
                  state_d = SHIFTING;
                  if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
            COMMIT: begin
               state_d = IDLE;
               if (bit_cnt_q != CNT_FULL || int'(f_addr) >= CH_COUNT) begin
                  err_d = 1'b1;
               end else begin
                  rd_addr_d = f_addr;
                  if (f_wr) begin
                     for (int i = 0; i < CH_COUNT; i++) begin
                        if (f_addr == ADDR_WIDTH'(i)) regs_d[i] = f_data;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Period of 2**DATA_WIDTH-1 makes all-ones duty fully on.
   always_comb begin
      pwm_cnt_d = (pwm_cnt_q == PWM_TOP) ? '0 : pwm_cnt_q + DATA_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         regs_q     <= {CH_COUNT{RESET_VALUE}};
         rd_addr_q  <= '0;
         err_q      <= 1'b0;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         tdo_q      <= 1'b0;
         pwm_cnt_q  <= '0;
         tck_prev_q <= 1'b0;
         upd_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         regs_q     <= regs_d;
         rd_addr_q  <= rd_addr_d;
         err_q      <= err_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         tdo_q      <= tdo_d;
         pwm_cnt_q  <= pwm_cnt_d;
         tck_prev_q <= tck_prev_d;
         upd_prev_q <= upd_prev_d;
      end
   end

   for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
      pwm_channel #(
         .DATA_WIDTH     (DATA_WIDTH),
         .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
      ) u_pwm (
         .clk     (clk),
         .rst     (rst),
         .duty    (regs_q[i]),
         .pwm_cnt (pwm_cnt_q),
         .led     (led[i])
      );
   end

   assign tap_tdo  = tdo_q;
   assign ch_value = regs_q;

endmodule
